// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: op codes, FSM encoding, result-width helper.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE_A = 3'd1,
        ST_ISSUE_B = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAP2    = 3'd4,
        ST_ABORT   = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // MUL and DIV return two bytes from the ALU, ADD and SUB return one.
    function automatic logic two_byte(input logic [1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; owns the last-served pointer.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       win_valid,
    output logic       win_id
);

    logic last_id;

    assign win_valid = |req;

    // On a tie the requester not served last wins; otherwise the sole requester.
    always_comb begin
        win_id = req[1];
        if (req == 2'b11) begin
            win_id = ~last_id;
        end
    end

    // Pointer starts at 1 so requester 0 takes the first tie; moves only on a grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_id <= 1'b1;
        end else if (accept && win_valid) begin
            last_id <= win_id;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Sequencer and round-robin arbiter in front of the shared serial 8-bit ALU.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | sample requests, latch winner's op/operands
// ISSUE_A  | BEGIN pulse with op_code and operand A, grant to winner
// ISSUE_B  | operand B on inbus, watchdog cleared
// WAIT     | waiting for END; watchdog counts, first result byte here
// CAP2     | second result byte (MUL high/low, DIV remainder/quotient)
// ABORT    | watchdog expired, one-cycle ALU reset
// DONE     | result strobe with requester id
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    input  logic [7:0]  a0,
    input  logic [7:0]  a1,
    input  logic [7:0]  b0,
    input  logic [7:0]  b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic [15:0] res,
    output logic        res_valid,
    output logic        res_id,
    output logic        res_err,
    output logic        alu_reset,
    output logic        alu_begin,
    output logic [1:0]  alu_op_code,
    output logic [7:0]  alu_inbus,
    input  logic [7:0]  alu_outbus,
    input  logic        alu_end
);

    localparam int               WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

    state_t          state;
    logic [1:0]      op_q;
    logic [7:0]      b_q;
    logic [7:0]      byte0_q;
    logic            id_q;
    logic [WD_W-1:0] wdog;
    logic            accept;
    logic            win_valid;
    logic            win_id;

    assign accept = (state == ST_IDLE);
    assign busy   = (state != ST_IDLE);

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       ({req1, req0}),
        .accept    (accept),
        .win_valid (win_valid),
        .win_id    (win_id)
    );

    // Sequencer: every output is set on entry to the state that owns it, so none
    // of them depends combinationally on req or alu_end.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            alu_begin   <= 1'b0;
            alu_reset   <= 1'b1;
            alu_op_code <= 2'b00;
            alu_inbus   <= 8'h00;
            res         <= 16'h0000;
            res_valid   <= 1'b0;
            res_id      <= 1'b0;
            res_err     <= 1'b0;
            op_q        <= 2'b00;
            b_q         <= 8'h00;
            byte0_q     <= 8'h00;
            id_q        <= 1'b0;
            wdog        <= '0;
        end else begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            alu_begin <= 1'b0;
            alu_reset <= 1'b0;
            res_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        id_q        <= win_id;
                        op_q        <= win_id ? op1 : op0;
                        b_q         <= win_id ? b1 : b0;
                        gnt0        <= ~win_id;
                        gnt1        <= win_id;
                        alu_begin   <= 1'b1;
                        alu_op_code <= win_id ? op1 : op0;
                        alu_inbus   <= win_id ? a1 : a0;
                        state       <= ST_ISSUE_A;
                    end
                end
                ST_ISSUE_A: begin
                    alu_inbus <= b_q;
                    state     <= ST_ISSUE_B;
                end
                ST_ISSUE_B: begin
                    wdog  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // END wins over the watchdog on the last allowed cycle.
                    if (alu_end) begin
                        byte0_q <= alu_outbus;
                        if (two_byte(op_q)) begin
                            state <= ST_CAP2;
                        end else begin
                            res       <= {8'h00, alu_outbus};
                            res_err   <= 1'b0;
                            res_id    <= id_q;
                            res_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end else if (wdog == WD_LAST) begin
                        alu_reset <= 1'b1;
                        state     <= ST_ABORT;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_CAP2: begin
                    res       <= {byte0_q, alu_outbus};
                    res_err   <= 1'b0;
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_ABORT: begin
                    res       <= 16'h0000;
                    res_err   <= 1'b1;
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU on the far side, arithmetic reference model.
module tb_alu_arbiter;

    localparam int TIMEOUT = 64;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [1:0]  op0, op1;
    logic [7:0]  a0, a1, b0, b1;
    logic        gnt0, gnt1, busy;
    logic [15:0] res;
    logic        res_valid, res_id, res_err;
    logic        alu_reset, alu_begin;
    logic [1:0]  alu_op_code;
    logic [7:0]  alu_inbus;
    logic [7:0]  alu_outbus;
    logic        alu_end;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .req1        (req1),
        .op0         (op0),
        .op1         (op1),
        .a0          (a0),
        .a1          (a1),
        .b0          (b0),
        .b1          (b1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .busy        (busy),
        .res         (res),
        .res_valid   (res_valid),
        .res_id      (res_id),
        .res_err     (res_err),
        .alu_reset   (alu_reset),
        .alu_begin   (alu_begin),
        .alu_op_code (alu_op_code),
        .alu_inbus   (alu_inbus),
        .alu_outbus  (alu_outbus),
        .alu_end     (alu_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic: one byte for ADD/SUB, {hi,lo} for MUL, {rem,quot} for DIV.
    function automatic logic [15:0] ref_result(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int x, y;
        x = a;
        y = b;
        case (op)
            2'b00:   return 16'((x + y) % 256);
            2'b01:   return 16'((x - y + 256) % 256);
            2'b10:   return 16'(x * y);
            default: return (y == 0) ? 16'hFFFF : 16'(((x % y) * 256) + (x / y));
        endcase
    endfunction

    // Behavioural ALU: END end_delay cycles after the operand-B cycle.
    int         end_delay = 4;
    bit         end_never = 0;
    int         m_phase = 0;
    int         m_cnt = 0;
    logic [1:0] m_op;
    logic [7:0] m_a, m_b;
    logic [15:0] m_full;

    always @(negedge clk) begin
        alu_end    = 1'b0;
        alu_outbus = 8'h00;
        if (alu_reset) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (alu_begin) begin
                    m_op    = alu_op_code;
                    m_a     = alu_inbus;
                    m_phase = 1;
                end
                1: begin
                    m_b     = alu_inbus;
                    m_cnt   = end_delay;
                    m_phase = 2;
                end
                2: begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt <= 0 && !end_never) begin
                        m_full  = ref_result(m_op, m_a, m_b);
                        alu_end = 1'b1;
                        if (m_op[1]) begin
                            alu_outbus = m_full[15:8];
                            m_phase    = 3;
                        end else begin
                            alu_outbus = m_full[7:0];
                            m_phase    = 0;
                        end
                    end
                end
                default: begin
                    alu_outbus = m_full[7:0];
                    m_phase    = 0;
                end
            endcase
        end
    end

    // Event monitor: grants, BEGIN pulses, watchdog resets, result strobes.
    int cyc = 0;
    bit gnt_q[$];
    int gnt_cyc[$];
    bit gnt_prev = 0;
    int gnt_double = 0;
    int n_begin = 0;
    int n_rst = 0;
    int n_valid = 0;

    always @(negedge clk) begin
        cyc++;
        if (gnt0 || gnt1) begin
            gnt_q.push_back(gnt1);
            gnt_cyc.push_back(cyc);
            if (gnt_prev) gnt_double++;
        end
        gnt_prev = gnt0 || gnt1;
        if (alu_begin) n_begin++;
        if (alu_reset && reset) n_rst++;
        if (res_valid) n_valid++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Issue one request from an idle DUT and collect what comes back.
    task automatic run_op(input bit id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          output bit gnt_ok, output int lat, output logic [15:0] r,
                          output logic rid, output logic rerr);
        int guard;
        if (id) begin
            req1 = 1'b1; op1 = op; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; op0 = op; a0 = a; b0 = b;
        end
        tick();
        gnt_ok = id ? (gnt1 && !gnt0) : (gnt0 && !gnt1);
        req0 = 1'b0;
        req1 = 1'b0;
        lat = 0;
        guard = 0;
        while (!res_valid && guard < 500) begin
            tick();
            lat++;
            guard++;
        end
        if (!res_valid) lat = -1;
        r    = res;
        rid  = res_id;
        rerr = res_err;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({gnt0, gnt1, alu_begin, busy, res_valid, res_err, res_id} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b want=0000000", {gnt0, gnt1, alu_begin, busy, res_valid, res_err, res_id});
        end
        checks++;
        if ({alu_op_code, alu_inbus, res} !== 26'h0) begin
            errors++;
            $display("FAIL reset_data op=%h inbus=%h res=%h want all zero", alu_op_code, alu_inbus, res);
        end
        checks++;
        if (alu_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_alu_reset got=%b want=1", alu_reset);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (alu_reset !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got=%b want=0", alu_reset);
        end
    endtask

    task automatic test_contention();
        int v0, bg0, d0, g0, k, guard;
        logic        rid_a[4];
        logic [15:0] res_a[4];
        end_delay = 1;
        g0 = gnt_q.size();
        bg0 = n_begin;
        d0 = gnt_double;
        v0 = n_valid;
        req0 = 1'b1; op0 = 2'b00; a0 = 8'd10; b0 = 8'd20;
        req1 = 1'b1; op1 = 2'b00; a1 = 8'd30; b1 = 8'd40;
        k = 0;
        guard = 0;
        while (k < 4 && guard < 200) begin
            tick();
            guard++;
            if (res_valid) begin
                rid_a[k] = res_id;
                res_a[k] = res;
                k++;
                if (k == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        checks++;
        if (k != 4) begin
            errors++;
            $display("FAIL contention_results got=%0d want=4", k);
        end
        checks++;
        if (gnt_q.size() < g0 + 4) begin
            errors++;
            $display("FAIL contention_grants got=%0d want=4", gnt_q.size() - g0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (gnt_q[g0 + i] !== 1'(i % 2)) begin
                    errors++;
                    $display("FAIL contention_order[%0d] got=%0d want=%0d", i, gnt_q[g0 + i], i % 2);
                end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (gnt_cyc[g0 + i + 1] - gnt_cyc[g0 + i] != 5) begin
                    errors++;
                    $display("FAIL contention_gap[%0d] got=%0d want=5", i, gnt_cyc[g0 + i + 1] - gnt_cyc[g0 + i]);
                end
            end
        end
        checks++;
        if (n_begin - bg0 != 4 || gnt_double != d0) begin
            errors++;
            $display("FAIL contention_pulses begins=%0d doubles=%0d want 4 and 0", n_begin - bg0, gnt_double - d0);
        end
        for (int i = 0; i < k; i++) begin
            checks++;
            if (rid_a[i] !== 1'(i % 2) || res_a[i] !== ((i % 2) ? 16'd70 : 16'd30)) begin
                errors++;
                $display("FAIL contention_res[%0d] got id=%b res=%h want id=%0d res=%h", i, rid_a[i], res_a[i],
                         i % 2, (i % 2) ? 16'd70 : 16'd30);
            end
        end
    endtask

    task automatic test_fixed_ops();
        bit g; int lat; logic [15:0] r; logic rid, rerr;
        end_delay = 4;
        // ADD 56+89
        run_op(1'b0, 2'b00, 8'd56, 8'd89, g, lat, r, rid, rerr);
        checks++;
        if (!g || lat != 6) begin
            errors++;
            $display("FAIL add_timing gnt_ok=%0d lat=%0d want 1 and 6", g, lat);
        end
        checks++;
        if (r !== 16'h0091 || rid !== 1'b0 || rerr !== 1'b0) begin
            errors++;
            $display("FAIL add_result got res=%h id=%b err=%b want 0091/0/0", r, rid, rerr);
        end
        // MUL 56*89
        run_op(1'b1, 2'b10, 8'd56, 8'd89, g, lat, r, rid, rerr);
        checks++;
        if (!g || lat != 7) begin
            errors++;
            $display("FAIL mul_timing gnt_ok=%0d lat=%0d want 1 and 7", g, lat);
        end
        checks++;
        if (r !== 16'h1378 || rid !== 1'b1 || rerr !== 1'b0) begin
            errors++;
            $display("FAIL mul_result got res=%h id=%b err=%b want 1378/1/0", r, rid, rerr);
        end
        // DIV 200/89
        run_op(1'b0, 2'b11, 8'd200, 8'd89, g, lat, r, rid, rerr);
        checks++;
        if (r !== 16'h1602 || rid !== 1'b0 || lat != 7) begin
            errors++;
            $display("FAIL div_result got res=%h id=%b lat=%0d want 1602/0/7", r, rid, lat);
        end
    endtask

    task automatic test_random();
        bit g; int lat; logic [15:0] r; logic rid, rerr;
        bit id; logic [1:0] op; logic [7:0] a, b; int want_lat; logic [15:0] want;
        for (int i = 0; i < 16; i++) begin
            id = 1'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 3));
            a = 8'($urandom);
            b = 8'($urandom_range(1, 255));
            end_delay = $urandom_range(1, 8);
            want = ref_result(op, a, b);
            want_lat = end_delay + 2 + ((op >= 2'b10) ? 1 : 0);
            run_op(id, op, a, b, g, lat, r, rid, rerr);
            checks++;
            if (!g || lat != want_lat || rid !== id || rerr !== 1'b0 || r !== want) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%0d b=%0d got res=%h id=%b err=%b lat=%0d gnt_ok=%0d want res=%h id=%b lat=%0d",
                         i, op, a, b, r, rid, rerr, lat, g, want, id, want_lat);
            end
        end
    endtask

    task automatic test_watchdog();
        bit g; int lat; logic [15:0] r; logic rid, rerr; int rst0;
        end_never = 1;
        rst0 = n_rst;
        run_op(1'b1, 2'b00, 8'd3, 8'd4, g, lat, r, rid, rerr);
        checks++;
        if (lat != TIMEOUT + 3 || r !== 16'h0000 || rerr !== 1'b1 || rid !== 1'b1) begin
            errors++;
            $display("FAIL watchdog_abort got lat=%0d res=%h err=%b id=%b want %0d/0000/1/1", lat, r, rerr, rid, TIMEOUT + 3);
        end
        checks++;
        if (n_rst - rst0 != 1) begin
            errors++;
            $display("FAIL watchdog_alu_reset got=%0d pulses want=1", n_rst - rst0);
        end
        end_never = 0;
        end_delay = 2;
        run_op(1'b0, 2'b00, 8'd1, 8'd1, g, lat, r, rid, rerr);
        checks++;
        if (r !== 16'h0002 || rerr !== 1'b0 || lat != 4) begin
            errors++;
            $display("FAIL watchdog_recover got res=%h err=%b lat=%0d want 0002/0/4", r, rerr, lat);
        end
        rst0 = n_rst;
        end_delay = TIMEOUT;
        run_op(1'b1, 2'b01, 8'd100, 8'd30, g, lat, r, rid, rerr);
        checks++;
        if (r !== 16'd70 || rerr !== 1'b0 || lat != TIMEOUT + 2 || n_rst != rst0) begin
            errors++;
            $display("FAIL watchdog_last_cycle got res=%h err=%b lat=%0d resets=%0d want 0046/0/%0d/0",
                     r, rerr, lat, n_rst - rst0, TIMEOUT + 2);
        end
    endtask

    task automatic test_reset_wait();
        int v0, guard;
        end_never = 1;
        req0 = 1'b1; op0 = 2'b10; a0 = 8'd7; b0 = 8'd9;
        tick();
        req0 = 1'b0;
        repeat (8) tick();
        v0 = n_valid;
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if ({gnt0, gnt1, alu_begin, busy, res_valid, res_err, res_id} !== 7'b0 ||
            {alu_op_code, alu_inbus, res} !== 26'h0 || alu_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_wait_outputs flags=%b op=%h inbus=%h res=%h alu_reset=%b want zeros and alu_reset=1",
                     {gnt0, gnt1, alu_begin, busy, res_valid, res_err, res_id}, alu_op_code, alu_inbus, res, alu_reset);
        end
        reset = 1'b1;
        end_never = 0;
        repeat (TIMEOUT + 10) tick();
        checks++;
        if (n_valid != v0) begin
            errors++;
            $display("FAIL reset_wait_no_result got=%0d strobes want=0", n_valid - v0);
        end
        end_delay = 3;
        req0 = 1'b1; op0 = 2'b00; a0 = 8'd5; b0 = 8'd6;
        req1 = 1'b1; op1 = 2'b01; a1 = 8'd9; b1 = 8'd2;
        tick();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_wait_tie got gnt0=%b gnt1=%b want 1/0", gnt0, gnt1);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        guard = 0;
        while (!res_valid && guard < 100) begin
            tick();
            guard++;
        end
        checks++;
        if (res_valid !== 1'b1 || res !== 16'd11 || res_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_wait_tie_result got valid=%b res=%h id=%b want 1/000b/0", res_valid, res, res_id);
        end
        tick();
    endtask

    initial begin
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 2'b00; op1 = 2'b00;
        a0 = 8'h00; a1 = 8'h00; b0 = 8'h00; b1 = 8'h00;
        test_reset();
        test_contention();
        test_fixed_ops();
        test_random();
        test_watchdog();
        test_reset_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
